// File: rtl/brightness_pkg.sv
// Shared definitions for the brightness pipeline RAM movers (ram_loader / ram_storer).
package brightness_pkg;

  localparam int DEF_RAM_ADDR_WIDTH = 6;
  localparam int DEF_RAM_DATA_WIDTH = 8;
  localparam int DEF_PE_DATA_WIDTH  = 16;
  localparam int DEF_DEPTH          = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pe_saturate.sv
// Clamps one signed PE result lane into an unsigned pixel range.
module pe_saturate
  import brightness_pkg::*;
#(
  parameter int IN_W  = DEF_PE_DATA_WIDTH,
  parameter int OUT_W = DEF_RAM_DATA_WIDTH
) (
  input  logic signed [IN_W-1:0] value,
  output logic        [OUT_W-1:0] pixel
);

  localparam logic signed [IN_W-1:0] MAX_VAL = IN_W'((1 << OUT_W) - 1);

  function automatic logic [OUT_W-1:0] saturate(input logic signed [IN_W-1:0] v);
    logic [OUT_W-1:0] result;
    if (v < 0) begin
      result = '0;
    end else if (v > MAX_VAL) begin
      result = '1;
    end else begin
      result = v[OUT_W-1:0];
    end
    return result;
  endfunction

  assign pixel = saturate(value);

endmodule

// File: rtl/ram_storer.sv
// Captures blocks of DEPTH PE lanes and writes them, saturated to pixels, into
// consecutive RAM locations until the whole RAM has been filled once.
module ram_storer
  import brightness_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
  parameter int RAM_DATA_WIDTH = DEF_RAM_DATA_WIDTH,
  parameter int PE_DATA_WIDTH  = DEF_PE_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0]  data_in,
  input  logic                            data_valid,
  output logic                            data_ready,
  output logic                            ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]       ram_address,
  output logic [RAM_DATA_WIDTH-1:0]       ram_data,
  output logic                            done
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]          LAST_WORD  = CNT_W'(DEPTH - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] TOP_ADDR   = '1;
  localparam logic [RAM_ADDR_WIDTH-1:0] BLOCK_STEP = RAM_ADDR_WIDTH'(DEPTH);

  state_t state, next_state;

  logic [RAM_ADDR_WIDTH-1:0]       base_addr;
  logic [RAM_ADDR_WIDTH-1:0]       write_addr;
  logic [RAM_ADDR_WIDTH-1:0]       addr_hold;
  logic [RAM_DATA_WIDTH-1:0]       data_hold;
  logic [RAM_DATA_WIDTH-1:0]       write_data;
  logic [CNT_W-1:0]                word_counter;
  logic signed [PE_DATA_WIDTH-1:0] lane_p0 [DEPTH];
  logic [RAM_DATA_WIDTH-1:0]       pixel_p0 [DEPTH];

  logic accept;
  logic last_word;
  logic arm;

  assign accept     = (state == WAIT) && data_valid;
  assign last_word  = (state == WRITE) && (word_counter == LAST_WORD);
  assign arm        = start && ((state == IDLE) || (state == DONE));
  assign write_addr = base_addr + RAM_ADDR_WIDTH'(word_counter);
  assign write_data = pixel_p0[word_counter];

  // Stage p0: captured lanes feed the saturators; writes read them one per cycle
  for (genvar k = 0; k < DEPTH; k++) begin : g_sat
    pe_saturate #(
      .IN_W  (PE_DATA_WIDTH),
      .OUT_W (RAM_DATA_WIDTH)
    ) u_sat (
      .value (lane_p0[k]),
      .pixel (pixel_p0[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = WAIT;
      WAIT:    if (data_valid) next_state = WRITE;
      WRITE:   if (last_word) next_state = (write_addr == TOP_ADDR) ? DONE : WAIT;
      DONE:    if (start) next_state = WAIT;
      default: next_state = IDLE;
    endcase
  end

  // Address/data are live during WRITE and otherwise replay the last write
  always_comb begin
    data_ready  = (state == WAIT);
    ram_we      = (state == WRITE);
    done        = (state == DONE);
    ram_address = ram_we ? write_addr : addr_hold;
    ram_data    = ram_we ? write_data : data_hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_addr    <= '0;
      word_counter <= '0;
      addr_hold    <= '0;
      data_hold    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        lane_p0[k] <= '0;
      end
    end else begin
      if (arm) begin
        base_addr <= '0;
      end
      if (accept) begin
        word_counter <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          lane_p0[k] <= data_in[k*PE_DATA_WIDTH +: PE_DATA_WIDTH];
        end
      end
      if (state == WRITE) begin
        addr_hold    <= write_addr;
        data_hold    <= write_data;
        word_counter <= last_word ? '0 : word_counter + 1'b1;
        // Full RAM wraps base_addr back to zero exactly as DONE is entered
        if (last_word) begin
          base_addr <= base_addr + BLOCK_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_storer.sv
// Randomized scoreboard bench for ram_storer against a block-level reference model.
module tb_ram_storer;

  localparam int AW     = 6;
  localparam int DW     = 8;
  localparam int PW     = 16;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 1 << AW;

  typedef logic [DEPTH-1:0][PW-1:0] lanes_t;
  typedef struct { int addr; int data; int cyc; } wr_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [PW*DEPTH-1:0]   data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic                  ram_we;
  logic [AW-1:0]         ram_address;
  logic [DW-1:0]         ram_data;
  logic                  done;

  always #5 clk = ~clk;

  ram_storer #(
    .RAM_ADDR_WIDTH (AW),
    .RAM_DATA_WIDTH (DW),
    .PE_DATA_WIDTH  (PW),
    .DEPTH          (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .ram_we      (ram_we),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .done        (done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int armed = 0;
  int done_from = -1;
  int next_free = 0;
  int base = 0;
  int accepted = 0;
  int rst_count = 0;
  int model_t;
  wr_t sb[$];

  function automatic int sat_ref(input logic [PW-1:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  function automatic bit ready_at(input int t);
    return (armed != 0) && (done_from < 0) && (t >= next_free);
  endfunction

  function automatic bit done_at(input int t);
    return (done_from >= 0) && (t >= done_from);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a pass is armed, blocks are accepted whenever no writes are
  // outstanding, and each accepted block schedules DEPTH writes on the next cycles.
  initial begin
    forever begin
      @(posedge clk);
      model_t = cyc;
      if (reset) begin
        armed = 0;
        done_from = -1;
        next_free = 0;
        base = 0;
        sb.delete();
        rst_count++;
      end else if (start && (armed == 0 || done_at(model_t))) begin
        armed = 1;
        done_from = -1;
        base = 0;
        next_free = model_t + 1;
      end else if (ready_at(model_t) && data_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          sb.push_back(wr_t'{base + i, sat_ref(data_in[i*PW +: PW]), model_t + 1 + i});
        end
        base += DEPTH;
        next_free = model_t + DEPTH + 1;
        accepted++;
        if (base == NWORDS) begin
          base = 0;
          done_from = model_t + DEPTH + 1;
        end
      end
      cyc = model_t + 1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes a write
  initial begin
    int seen_rst;
    int last_addr;
    int last_data;
    wr_t e;
    seen_rst = 0;
    last_addr = 0;
    last_data = 0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (rst_count != seen_rst) begin
          seen_rst = rst_count;
          last_addr = 0;
          last_data = 0;
        end
        chk("data_ready", int'(data_ready), int'(ready_at(cyc)));
        chk("done", int'(done), int'(done_at(cyc)));
        if (ram_we) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %0d with nothing queued (cycle %0d)",
                     ram_address, ram_data, cyc);
          end else begin
            e = sb.pop_front();
            chk("write_addr", int'(ram_address), e.addr);
            chk("write_data", int'(ram_data), e.data);
            chk("write_cycle", cyc, e.cyc);
            last_addr = e.addr;
            last_data = e.data;
          end
        end else begin
          if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write: ram_we 0, required write addr %0d data %0d (cycle %0d)",
                     e.addr, e.data, cyc);
          end
          chk("hold_addr", int'(ram_address), last_addr);
          chk("hold_data", int'(ram_data), last_data);
        end
      end
    end
  end

  function automatic lanes_t mk(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                input logic [PW-1:0] c, input logic [PW-1:0] d);
    lanes_t r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    r[3] = d;
    return r;
  endfunction

  function automatic logic [PW-1:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return PW'($urandom());
      1:       return PW'($urandom_range(0, 255));
      2:       return PW'($urandom_range(256, 4000));
      default: return PW'(0 - int'($urandom_range(1, 500)));
    endcase
  endfunction

  function automatic lanes_t rand_block();
    lanes_t r;
    for (int i = 0; i < DEPTH; i++) r[i] = rand_lane();
    return r;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents a block and leaves data_valid high once it has been taken
  task automatic send_block(input lanes_t l);
    int n;
    n = accepted;
    data_in = l;
    data_valid = 1'b1;
    for (int w = 0; w < 50 && accepted == n; w++) begin
      @(negedge clk);
    end
    chk("handshake_count", accepted, n + 1);
  endtask

  initial begin
    lanes_t l;
    reset = 1'b1;
    start = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    pulse_start();
    send_block(mk(16'h0009, 16'h0002, 16'h0003, 16'h0004));
    send_block(mk(16'hFFF6, 16'h0100, 16'h00FF, 16'h0000));
    pulse_start();
    for (int b = 2; b < 16; b++) send_block(rand_block());
    repeat (12) @(negedge clk);

    l = rand_block();
    data_in = l;
    pulse_start();
    send_block(l);
    for (int b = 1; b < 5; b++) send_block(rand_block());
    data_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    pulse_start();
    send_block(rand_block());
    data_valid = 1'b0;
    repeat (10) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
